// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// mem_stage_lsu : MEM-stage load/store unit (IDLE/BUSY/DONE) driving a D-cache
//                 request/ack port; optional watchdog under LSU_TIMEOUT_EN.
// Revision      : 1.0  initial release
// ============================================================================
module mem_stage_lsu #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] result_in,
   input  logic [DATA_W-1:0] data2_in,
   input  logic [REG_W-1:0]  rd_in,
   input  logic              wb_memtoreg_in,
   input  logic              wb_regwrite_in,
   input  logic              mem_memread_in,
   input  logic              mem_memwrite_in,
   input  logic              ls_word_in,
   input  logic              ext_stall,
   output logic              lsu_stall,
   output logic              dc_req,
   output logic              dc_write,
   output logic [DATA_W-1:0] dc_addr,
   output logic [DATA_W-1:0] dc_wdata,
   output logic [3:0]        dc_wstrb,
   input  logic [DATA_W-1:0] dc_rdata,
   input  logic              dc_ack,
   output logic [DATA_W-1:0] wb_data_out,
   output logic [REG_W-1:0]  wb_rd_out,
   output logic              wb_regwrite_out,
   output logic              err_timeout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nx;

   logic              access;
   logic              timeout;
   logic              acked;
   logic              req_write;
   logic              req_word;
   logic [DATA_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [3:0]        req_wstrb;
   logic [7:0]        ld_byte;
   logic [DATA_W-1:0] ld_fmt;
   logic [DATA_W-1:0] ld_new;
   logic [DATA_W-1:0] ld_now;
   logic [DATA_W-1:0] load_data;

   assign access = mem_memread_in | mem_memwrite_in;
   // A watchdog expiry completes the access exactly like an acknowledge.
   assign acked  = (state == BUSY) && (dc_ack || timeout);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      lsu_stall = 1'b0;
      case (state)
         IDLE: begin
            if (access) begin
               lsu_stall = 1'b1;
               state_nx  = BUSY;
            end
         end
         BUSY: begin
            if (acked) begin
               state_nx = ext_stall ? DONE : IDLE;
            end else begin
               lsu_stall = 1'b1;
            end
         end
         DONE: begin
            if (!ext_stall) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Request is latched once on entry to BUSY so the cache sees stable fields.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_write <= 1'b0;
         req_word  <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
         req_wstrb <= 4'b0000;
      end else if (state == IDLE && access) begin
         req_write <= mem_memwrite_in;
         req_word  <= ls_word_in;
         req_addr  <= result_in;
         if (!mem_memwrite_in) begin
            req_wdata <= '0;
            req_wstrb <= 4'b0000;
         end else if (ls_word_in) begin
            req_wdata <= data2_in;
            req_wstrb <= 4'b1111;
         end else begin
            req_wdata <= {(DATA_W/8){data2_in[7:0]}};
            req_wstrb <= 4'b0001 << result_in[1:0];
         end
      end
   end

   assign dc_req   = (state == BUSY);
   assign dc_write = req_write;
   assign dc_addr  = {req_addr[DATA_W-1:2], 2'b00};
   assign dc_wdata = req_wdata;
   assign dc_wstrb = req_wstrb;

   always_comb begin
      ld_byte = dc_rdata[7:0];
      case (req_addr[1:0])
         2'd0:    ld_byte = dc_rdata[7:0];
         2'd1:    ld_byte = dc_rdata[15:8];
         2'd2:    ld_byte = dc_rdata[23:16];
         default: ld_byte = dc_rdata[31:24];
      endcase
   end

   assign ld_fmt = req_word ? dc_rdata : {{(DATA_W-8){ld_byte[7]}}, ld_byte};
   assign ld_new = timeout ? '0 : ld_fmt;
   // In the completion cycle the fresh value bypasses the capture register.
   assign ld_now = acked ? ld_new : load_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         load_data <= '0;
      end else if (acked) begin
         load_data <= ld_new;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_data_out     <= '0;
         wb_rd_out       <= '0;
         wb_regwrite_out <= 1'b0;
      end else if (!lsu_stall && !ext_stall) begin
         wb_data_out     <= wb_memtoreg_in ? ld_now : result_in;
         wb_rd_out       <= rd_in;
         wb_regwrite_out <= wb_regwrite_in;
      end
   end

`ifdef LSU_TIMEOUT_EN
   logic [7:0] busy_cnt;
   logic       err_q;

   // Expires on the 256th consecutive un-acknowledged BUSY cycle.
   assign timeout     = (state == BUSY) && !dc_ack && (busy_cnt == 8'hFF);
   assign err_timeout = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_cnt <= 8'h00;
         err_q    <= 1'b0;
      end else begin
         if (state != BUSY || dc_ack) begin
            busy_cnt <= 8'h00;
         end else begin
            busy_cnt <= busy_cnt + 8'h01;
         end
         if (timeout) begin
            err_q <= 1'b1;
         end
      end
   end
`else
   assign timeout     = 1'b0;
   assign err_timeout = 1'b0;
`endif

endmodule
`default_nettype wire
